// File: rtl/rv32ima_pkg.sv
// rv32ima_pkg: shared RAM/LSU types, access widths and lane-alignment helpers.
package rv32ima_pkg;
    typedef logic [31:0] word_t;
    localparam int LDST_WIDTH_W = 2;
    localparam logic [LDST_WIDTH_W-1:0] LDST_BYTE = 2'd0;
    localparam logic [LDST_WIDTH_W-1:0] LDST_HALF = 2'd1;
    localparam logic [LDST_WIDTH_W-1:0] LDST_WORD = 2'd2;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ram_state_t;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} arb_state_t;
    function automatic logic [3:0] lane_mask(input logic [LDST_WIDTH_W-1:0] width, input logic [1:0] off);
        return width == LDST_BYTE ? 4'b0001 << off : width == LDST_HALF ? 4'b0011 << off : 4'b1111;
    endfunction
    function automatic logic misaligned(input logic [LDST_WIDTH_W-1:0] width, input logic [1:0] off);
        return width == LDST_HALF ? off[0] : width != LDST_BYTE && off != 2'd0;
    endfunction
    function automatic word_t store_align(input word_t data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction
    function automatic word_t load_align(input word_t data, input logic [LDST_WIDTH_W-1:0] width, input logic [1:0] off);
        word_t s;
        s = data >> {off, 3'b000};
        return width == LDST_BYTE ? {24'b0, s[7:0]} : width == LDST_HALF ? {16'b0, s[15:0]} : s;
    endfunction
endpackage

// File: rtl/multi_port_ram_rr_arbiter.sv
// rr_arbiter: grants the first requester found after last_grant, wrapping around.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
    input logic [NUM_PORTS-1:0] req,
    input logic [IDX_W-1:0] last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic any
);
    int c;
    always_comb begin
        grant_idx = '0;
        any = 1'b0;
        c = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            c = (int'(last_grant) + k) % NUM_PORTS;
            if (!any && req[IDX_W'(c)]) begin
                any = 1'b1;
                grant_idx = IDX_W'(c);
            end
        end
        grant = any ? NUM_PORTS'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/multi_port_ram.sv
// multi_port_ram: one word-organised RAM shared by NUM_PORTS channels through a
// round-robin arbiter with fixed LATENCY and byte/half/word lane handling.
module multi_port_ram
    import rv32ima_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int DEPTH = 4096,
    parameter int LATENCY = 2
) (
    input logic ram_clk,
    input logic rst,
    input word_t ram_addr [NUM_PORTS],
    input word_t ram_store [NUM_PORTS],
    input logic ram_ren [NUM_PORTS],
    input logic ram_wen [NUM_PORTS],
    input logic [LDST_WIDTH_W-1:0] ram_width [NUM_PORTS],
    output word_t ram_load [NUM_PORTS],
    output ram_state_t ram_state [NUM_PORTS]
);
    localparam int IDX_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
    arb_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic err, err_n, arb_any, illegal, ren_q, wen_q;
    logic [IDX_W-1:0] last_grant, gnt_idx, arb_idx;
    logic [NUM_PORTS-1:0] req, gnt_oh, arb_oh;
    logic [AW+1:0] addr_q;
    logic [LDST_WIDTH_W-1:0] width_q;
    logic [3:0] wmask;
    word_t store_q, wdata;
    word_t mem [DEPTH];
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) req[i] = ram_ren[i] | ram_wen[i];
    end
    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_arb (
        .req(req),
        .last_grant(last_grant),
        .grant(arb_oh),
        .grant_idx(arb_idx),
        .any(arb_any)
    );
    assign illegal = (ram_ren[arb_idx] && ram_wen[arb_idx])
        || misaligned(ram_width[arb_idx], ram_addr[arb_idx][1:0])
        || {2'b00, ram_addr[arb_idx][31:2]} >= 32'(DEPTH);
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        err_n = err;
        case (state)
            IDLE: if (arb_any) begin
                err_n = illegal;
                cnt_n = CNT_W'(LATENCY - 1);
                state_n = illegal || LATENCY == 1 ? DONE : WAIT;
            end
            WAIT: begin
                cnt_n = cnt - CNT_W'(1);
                state_n = cnt == CNT_W'(1) ? DONE : WAIT;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge ram_clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            err <= 1'b0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            gnt_idx <= '0;
            gnt_oh <= '0;
            for (int i = 0; i < NUM_PORTS; i++) ram_load[i] <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            err <= err_n;
            if (state == IDLE && arb_any) begin
                gnt_idx <= arb_idx;
                gnt_oh <= arb_oh;
                addr_q <= ram_addr[arb_idx][AW+1:0];
                store_q <= ram_store[arb_idx];
                width_q <= ram_width[arb_idx];
                ren_q <= ram_ren[arb_idx];
                wen_q <= ram_wen[arb_idx];
            end
            if (state == DONE) begin
                last_grant <= gnt_idx;
                if (!err && ren_q) ram_load[gnt_idx] <= load_align(mem[addr_q[AW+1:2]], width_q, addr_q[1:0]);
            end
        end
    end
    assign wmask = lane_mask(width_q, addr_q[1:0]);
    assign wdata = store_align(store_q, addr_q[1:0]);
    // Storage is never cleared; reset only suppresses an in-flight write.
    always_ff @(posedge ram_clk) begin
        if (!rst && state == DONE && !err && wen_q)
            for (int b = 0; b < 4; b++) if (wmask[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
    end
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++)
            ram_state[i] = state == DONE && gnt_oh[i] ? (err ? RAM_ERROR : RAM_ACCESS) : req[i] ? RAM_BUSY : RAM_FREE;
    end
endmodule
